// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready handshake from the host into the UART transmit FIFO.
interface uart_tx_fifo_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter: handshake-fed byte FIFO followed by a tick-timed serialiser.
// Includes the baud generator shared with the receiver.

module baud_gen (
  input  logic       SCLK,
  input  logic       SCLR,
  input  logic [1:0] MODE,
  output logic       BAUD_CLK
);
  logic [2:0] div_cnt_reg;
  logic       baud_clk_reg;
  logic [2:0] half_last;

  // Half-period of BAUD_CLK in SCLK cycles, minus one: 8, 4, 2, 1 cycles.
  always_comb begin
    half_last = 3'd7;
    case (MODE)
      2'd0: half_last = 3'd7;
      2'd1: half_last = 3'd3;
      2'd2: half_last = 3'd1;
      2'd3: half_last = 3'd0;
      default: half_last = 3'd7;
    endcase
  end

  // >= keeps the divider sane when MODE drops below the current count.
  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      div_cnt_reg  <= 3'd0;
      baud_clk_reg <= 1'b0;
    end else if (div_cnt_reg >= half_last) begin
      div_cnt_reg  <= 3'd0;
      baud_clk_reg <= ~baud_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 3'd1;
    end
  end

  assign BAUD_CLK = baud_clk_reg;
endmodule

module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic          SCLK,
  input  logic          SCLR,
  input  logic [1:0]    MODE,
  uart_tx_fifo_if.slave bus,
  output logic          TX,
  output logic          TX_BUSY,
  output logic          TX_DONE
);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int STOP_TICKS = STOP_BITS * OVS;
  localparam int CNT_W      = $clog2(STOP_TICKS);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Tick extraction
  logic baud_clk;
  logic baud_clk_d_reg;
  logic tick;

  baud_gen u_baud_gen (
    .SCLK     (SCLK),
    .SCLR     (SCLR),
    .MODE     (MODE),
    .BAUD_CLK (baud_clk)
  );

  always_ff @(posedge SCLK) begin
    if (SCLR) baud_clk_d_reg <= 1'b0;
    else      baud_clk_d_reg <= baud_clk;
  end

  assign tick = baud_clk & ~baud_clk_d_reg;

  // FIFO storage and pointers
  logic [7:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  assign bus.TX_READY = (count_reg != FULL_CNT);
  assign fifo_empty   = (count_reg == '0);
  assign push         = bus.TX_VALID && bus.TX_READY;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (push && !SCLR) mem_reg[wr_ptr_reg] <= bus.TX_DATA;
  end

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Serialiser FSM
  state_t           state_reg, state_next;
  logic [7:0]       shift_reg, shift_next;
  logic [CNT_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic             tx_reg, tx_next;
  logic             done_reg, done_next;

  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      state_reg    <= IDLE;
      shift_reg    <= 8'd0;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= 3'd0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_reg       <= tx_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    done_next     = 1'b0;
    pop           = 1'b0;
    tx_next       = 1'b1;

    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            pop           = 1'b1;
            shift_next    = mem_reg[rd_ptr_reg];
            tick_cnt_next = '0;
            bit_cnt_next  = 3'd0;
            state_next    = START;
          end
        end
        START: begin
          if (tick_cnt_reg == BIT_LAST) begin
            tick_cnt_next = '0;
            state_next    = DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_reg == BIT_LAST) begin
            tick_cnt_next = '0;
            shift_next    = {1'b0, shift_reg[7:1]};
            if (bit_cnt_reg == 3'd7) begin
              bit_cnt_next = 3'd0;
              state_next   = STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_reg == STOP_LAST) begin
            done_next     = 1'b1;
            tick_cnt_next = '0;
            // Chain straight into the next frame so queued bytes leave with no idle gap.
            if (!fifo_empty) begin
              pop          = 1'b1;
              shift_next   = mem_reg[rd_ptr_reg];
              bit_cnt_next = 3'd0;
              state_next   = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Line level follows the next state so TX is a clean register output.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign TX      = tx_reg;
  assign TX_DONE = done_reg;
  assign TX_BUSY = (state_reg != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench: pushes record expected bytes, a line monitor decodes TX frames and compares.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  logic       sclk = 1'b0;
  logic       sclr;
  logic [1:0] mode;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  uart_tx_fifo_if bus_a();
  uart_tx_fifo_if bus_b();

  uart_tx_fifo #(.FIFO_DEPTH(4), .OVS(8), .STOP_BITS(1)) dut_a (
    .SCLK(sclk), .SCLR(sclr), .MODE(mode), .bus(bus_a),
    .TX(tx_a), .TX_BUSY(busy_a), .TX_DONE(done_a)
  );

  uart_tx_fifo #(.FIFO_DEPTH(4), .OVS(8), .STOP_BITS(2)) dut_b (
    .SCLK(sclk), .SCLR(sclr), .MODE(mode), .bus(bus_b),
    .TX(tx_b), .TX_BUSY(busy_b), .TX_DONE(done_b)
  );

  always #5 sclk = ~sclk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  expq[$];
  int          bcyc = 128;
  logic        use_b = 1'b0;
  logic        mon_en = 1'b0;
  logic        contig_chk = 1'b0;
  int          done_cnt_a = 0;
  int          done_cnt_b = 0;
  longint      cyc = 0;
  logic        tx_mon;

  assign tx_mon = use_b ? tx_b : tx_a;

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Line monitor: samples mid-bit using the bit length implied by the current MODE.
  logic       mon_prev = 1'b1;
  logic [7:0] mon_rx;
  logic       mon_ferr;
  longint     mon_fall, mon_last_fall;
  bit         mon_have_prev = 1'b0;
  int         mon_nstop;
  logic [7:0] mon_exp;

  initial begin : monitor
    forever begin
      @(negedge sclk);
      if (!contig_chk) mon_have_prev = 1'b0;
      if (mon_en && mon_prev === 1'b1 && tx_mon === 1'b0) begin
        mon_fall  = cyc;
        mon_nstop = use_b ? 2 : 1;
        mon_ferr  = 1'b0;
        if (contig_chk && mon_have_prev)
          check("frame_gap", 32'(mon_fall - mon_last_fall), 32'(10 * bcyc));
        mon_last_fall = mon_fall;
        mon_have_prev = 1'b1;
        repeat (bcyc / 2) @(negedge sclk);
        if (tx_mon !== 1'b0) mon_ferr = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (bcyc) @(negedge sclk);
          mon_rx[i] = tx_mon;
        end
        for (int s = 0; s < mon_nstop; s++) begin
          repeat (bcyc) @(negedge sclk);
          if (tx_mon !== 1'b1) mon_ferr = 1'b1;
        end
        mon_prev = tx_mon;
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%0h, want no frame", mon_rx);
        end else begin
          mon_exp = expq.pop_front();
          $display("frame dut=%s byte=0x%02h expected=0x%02h ferr=%0b", use_b ? "b" : "a",
                   mon_rx, mon_exp, mon_ferr);
          check("rx_data", 32'(mon_rx), 32'(mon_exp));
          check("rx_err", 32'(mon_ferr), 32'd0);
        end
      end else begin
        mon_prev = tx_mon;
      end
    end
  end

  // Every TX_DONE: BUSY must already be low unless more frames are still expected.
  initial begin : done_watch
    forever begin
      @(negedge sclk);
      if (done_a === 1'b1) begin
        done_cnt_a++;
        check("busy_at_done_a", 32'(busy_a), 32'(expq.size() != 0));
      end
      if (done_b === 1'b1) begin
        done_cnt_b++;
        check("busy_at_done_b", 32'(busy_b), 32'(expq.size() != 0));
      end
    end
  end

  task automatic push(input bit to_b, input logic [7:0] b, input bit expect_it);
    int n;
    n = 0;
    @(negedge sclk);
    if (to_b) begin bus_b.TX_DATA = b; bus_b.TX_VALID = 1'b1; end
    else      begin bus_a.TX_DATA = b; bus_a.TX_VALID = 1'b1; end
    while ((to_b ? bus_b.TX_READY : bus_a.TX_READY) !== 1'b1 && n < 5000) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 5000) begin
      check("push_timeout", 32'd0, 32'd1);
    end else if (expect_it) begin
      expq.push_back(b);
    end
    @(posedge sclk);
    #1;
    bus_a.TX_VALID = 1'b0;
    bus_b.TX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(expq.size() == 0 && busy_a === 1'b0 && busy_b === 1'b0) && n < limit) begin
      @(negedge sclk);
      n++;
    end
    check("idle_reached", 32'(n < limit), 32'd1);
    repeat (4) @(negedge sclk);
  endtask

  task automatic wait_fall_a();
    int n;
    n = 0;
    while (tx_a !== 1'b0 && n < 4000) begin
      @(negedge sclk);
      n++;
    end
    check("start_seen", 32'(n < 4000), 32'd1);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge sclk);
    mode = m;
    bcyc = 8 * (16 >> m);
  endtask

  int d0;

  initial begin
    sclr = 1'b1;
    mode = 2'd0;
    bus_a.TX_DATA = 8'h77; bus_a.TX_VALID = 1'b1;
    bus_b.TX_DATA = 8'h77; bus_b.TX_VALID = 1'b1;

    // 1: reset held with VALID asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_ready", 32'(bus_a.TX_READY), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
    end
    sclr = 1'b0;
    bus_a.TX_VALID = 1'b0;
    bus_b.TX_VALID = 1'b0;
    @(negedge sclk);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_ready", 32'(bus_a.TX_READY), 32'd1);
    mon_en = 1'b1;

    // 2: single frame 0xA5
    set_mode(2'd0);
    d0 = done_cnt_a;
    push(1'b0, 8'hA5, 1'b1);
    wait_idle(4000);
    check("done_count_single", 32'(done_cnt_a - d0), 32'd1);

    // 3: back-to-back frames with no idle gap
    set_mode(2'd3);
    contig_chk = 1'b1;
    d0 = done_cnt_a;
    push(1'b0, 8'h00, 1'b1);
    push(1'b0, 8'hFF, 1'b1);
    push(1'b0, 8'h3C, 1'b1);
    wait_idle(2000);
    contig_chk = 1'b0;
    check("done_count_three", 32'(done_cnt_a - d0), 32'd3);

    // 4: fill the FIFO while a frame is in flight
    push(1'b0, 8'h11, 1'b1);
    wait_fall_a();
    push(1'b0, 8'h22, 1'b1);
    push(1'b0, 8'h33, 1'b1);
    push(1'b0, 8'h44, 1'b1);
    push(1'b0, 8'h55, 1'b1);
    @(negedge sclk);
    check("full_ready_low", 32'(bus_a.TX_READY), 32'd0);
    d0 = done_cnt_a;
    push(1'b0, 8'h66, 1'b1);
    @(negedge sclk);
    check("fifth_after_pop", 32'(done_cnt_a - d0), 32'd1);
    wait_idle(3000);

    // 5: reset in data bit 3, then a clean frame
    mon_en = 1'b0;
    push(1'b0, 8'h55, 1'b0);
    wait_fall_a();
    repeat (70) @(negedge sclk);
    sclr = 1'b1;
    @(negedge sclk);
    check("midrst_tx", 32'(tx_a), 32'd1);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_ready", 32'(bus_a.TX_READY), 32'd1);
    sclr = 1'b0;
    d0 = done_cnt_a;
    repeat (400) @(negedge sclk);
    check("midrst_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("midrst_tx_idle", 32'(tx_a), 32'd1);
    mon_en = 1'b1;
    push(1'b0, 8'h12, 1'b1);
    wait_idle(2000);

    // 6: every MODE, then two stop bits
    for (int m = 0; m < 4; m++) begin
      set_mode(2'(m));
      push(1'b0, 8'h00, 1'b1);
      push(1'b0, 8'h5A, 1'b1);
      push(1'b0, 8'hFF, 1'b1);
      wait_idle(8000);
    end
    use_b = 1'b1;
    set_mode(2'd2);
    d0 = done_cnt_b;
    push(1'b1, 8'h00, 1'b1);
    push(1'b1, 8'h5A, 1'b1);
    push(1'b1, 8'hFF, 1'b1);
    wait_idle(3000);
    check("done_count_stop2", 32'(done_cnt_b - d0), 32'd3);
    use_b = 1'b0;

    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
